// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 255-byte FIFO-fed UART transmitter, 8N1 or 8E1 with UART_TX_PARITY_EN
module uart_tx_engine (
  input  logic        clk_125,
  input  logic        rst_n_125,
  input  logic        tx_fifo_wr,
  input  logic [31:0] tx_fifo_wr_data,
  output logic [7:0]  tx_fifo_wr_num,
  input  logic        tx_en,
  input  logic [15:0] baud_div,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_ovf
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  mem_q [256];
  logic [7:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d, timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d, ovf_q, ovf_d;
  logic        pop, wr_acc, bit_end;
  logic        unused_data;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign unused_data    = ^tx_fifo_wr_data[31:8];
  assign tx_fifo_wr_num = count_q;
  assign uart_txd       = txd_q;
  assign tx_busy        = (state_q != S_IDLE);
  assign tx_ovf         = ovf_q;

  always_comb begin
    pop      = (state_q == S_IDLE) && (count_q != 8'd0) && tx_en;
    // 256 slots with a 255 cap keep a simultaneous write and pop on distinct entries
    wr_acc   = tx_fifo_wr && ((count_q != 8'hFF) || pop);
    bit_end  = (timer_q == div_q - 16'd1);
    ovf_d    = tx_fifo_wr && !wr_acc;
    wr_ptr_d = wr_acc ? wr_ptr_q + 8'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 8'd1 : rd_ptr_q;
    count_d  = count_q + {7'd0, wr_acc} - {7'd0, pop};
    state_d  = state_q;
    shift_d  = shift_q;
    div_d    = div_q;
    timer_d  = timer_q + 16'd1;
    bit_d    = bit_q;
    txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = 16'd0;
        txd_d   = 1'b1;
        if (pop) begin
          state_d  = S_START;
          shift_d  = mem_q[rd_ptr_q];
          div_d    = (baud_div < 16'd2) ? 16'd2 : baud_div;
          bit_d    = 3'd0;
          txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          timer_d = 16'd0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = 16'd0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = parity_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          timer_d = 16'd0;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          timer_d = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (wr_acc) mem_q[wr_ptr_q] <= tx_fifo_wr_data[7:0];
  end

  always_ff @(posedge clk_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= 8'd0;
      rd_ptr_q <= 8'd0;
      count_q  <= 8'd0;
      shift_q  <= 8'd0;
      div_q    <= 16'd2;
      timer_q  <= 16'd0;
      bit_q    <= 3'd0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have: clk_125  in  1  single 125 MHz clock; all logic rising-edge.
REQ-002 SHALL have: rst_n_125  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: tx_fifo_wr  in  1  write strobe, one word per high cycle.
REQ-004 SHALL have: tx_fifo_wr_data  in  32  write word; only bits [7:0] stored.
REQ-005 SHALL have: tx_fifo_wr_num  out  8  FIFO occupancy in bytes, 0..255.
REQ-006 SHALL have: tx_en  in  1  transmitter enable.
REQ-007 SHALL have: baud_div  in  16  clk_125 cycles per UART bit.
REQ-008 SHALL have: uart_txd  out  1  serial line, idle high.
REQ-009 SHALL have: tx_busy  out  1  high from frame start through last stop-bit cycle.
REQ-010 SHALL have: tx_ovf  out  1  one-cycle pulse when a write is dropped.

Function
REQ-011 FIFO SHALL hold 255 bytes max; circular storage, 8-bit read/write pointers wrapping 255->0.
REQ-012 tx_fifo_wr_num SHALL update the cycle after a write or pop; simultaneous write and pop leaves it unchanged.
REQ-013 Write while tx_fifo_wr_num==255 and no pop that cycle SHALL be dropped, pointers unchanged, tx_ovf=1 next cycle; write to a full FIFO coincident with a pop SHALL be accepted.
REQ-014 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: when tx_fifo_wr_num!=0 and tx_en=1, SHALL pop one byte into a shift register, latch baud_div (values <2 forced to 2), enter START next cycle.
REQ-016 Bit timer SHALL count latched divisor cycles per bit; uart_txd registered: START=0, DATA=LSB first 8 bits, STOP=1.
REQ-017 After the STOP bit period SHALL return to IDLE; a further pop may occur in that IDLE cycle, so back-to-back frames have exactly one idle clock gap.
REQ-018 tx_en deassertion mid-frame SHALL complete the current frame; no new pop while tx_en=0.
REQ-019 baud_div changes mid-frame SHALL take effect only at the next frame start.
REQ-020 Byte written into empty FIFO at cycle N with tx_en=1 and FSM IDLE: count=1 at N+1, pop at N+1, uart_txd low from N+2.

Reset
REQ-021 On rst_n_125=0, immediately: FIFO empty, pointers 0, tx_fifo_wr_num=0, FSM IDLE, uart_txd=1, tx_busy=0, tx_ovf=0, bit timer 0.
REQ-022 Reset mid-frame SHALL abort the frame and drive uart_txd=1 asynchronously; buffered bytes lost.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, transmitting even parity (XOR of 8 data bits), frame 11 bits.
REQ-024 UART_TX_PARITY_EN undefined: no PARITY state or logic, frame 10 bits (8N1).

Verification
REQ-025 baud_div=16, tx_en=1, write 0x000000A5 -> uart_txd low for 16 cycles starting 2 cycles after write, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop high; frame 160 cycles (176 with parity, parity bit 0).
REQ-026 tx_en=0, 256 consecutive writes -> tx_fifo_wr_num=255, tx_ovf pulses once on the 256th, count stays 255.
REQ-027 baud_div=4, write 0x11,0x22,0x33 back-to-back -> three frames with 1 idle clock between; count 3->0; bytes in order.
REQ-028 baud_div=0 -> bit period 2 cycles.
REQ-029 Reset asserted mid DATA of 0x5A -> uart_txd=1, tx_busy=0, count=0 immediately; after release no frame without new write.
REQ-030 Count 255, tx_en=1, write coincident with pop -> write accepted, no tx_ovf, count stays 255.
